// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 (1-5-10) constants and types used by the activation
// blocks. Holds the field widths, bias, special encodings, the operand class
// encoding and the stage-A record of base2_k_combiner.
package fp16_pkg;

    localparam int FP16_W = 16;
    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int SIG_W  = MAN_W + 1;
    localparam int BIAS   = 15;
    localparam int EXP_MAX = (1 << EXP_W) - 1;   // all-ones exponent: Inf/NaN

    localparam logic [FP16_W-1:0] QNAN = 16'h7E00;
    localparam logic [FP16_W-1:0] PINF = 16'h7C00;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } fp_cls_e;

    // Stage A record: sign, class, normalized significand (bit10 = 1 for
    // finite non-zero) and biased exponent after adding the clamped k.
    typedef struct packed {
        logic               sign;
        fp_cls_e            cls;
        logic [SIG_W-1:0]   sig;
        logic [9:0]         e_eff;   // two's complement
    } stage_a_t;

endpackage

// File: rtl/fp16_lzc11.sv
// fp16_lzc11: 11-bit leading-zero count, used to normalize FP16 subnormals.
// Ports:
//   a   - 11-bit input vector
//   cnt - number of leading zeros from bit 10 (11 when a == 0)
module fp16_lzc11 (
    input  logic [10:0] a,
    output logic [3:0]  cnt
);

    // Scan upward so the highest set bit is the last one to write cnt.
    always_comb begin
        cnt = 4'd11;
        for (int i = 0; i < 11; i++) begin
            if (a[i]) cnt = 4'(10 - i);
        end
    end

endmodule

// File: rtl/base2_k_combiner.sv
// base2_k_combiner: y = p * 2^kc for an FP16 operand p, where kc is k_i
// clamped to [K_MIN, K_MAX]. Two-stage pipeline, one result per cycle,
// no backpressure.
//   Stage A: classify p, normalize subnormals, form e_eff = e + kc.
//   Stage B: pack result; overflow -> Inf, underflow -> RNE subnormal/zero.
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset
//   valid_i          - k_i / p_i valid this cycle
//   k_i              - signed 8-bit exponent adjust
//   p_i              - FP16 operand
//   y_o, valid_o     - registered FP16 result and its valid
// Only DW = 16 (FP16) is supported.
module base2_k_combiner
    import fp16_pkg::*;
#(
    parameter int DW    = 16,
    parameter int K_MIN = -32,
    parameter int K_MAX = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          valid_i,
    input  logic [7:0]    k_i,
    input  logic [DW-1:0] p_i,
    output logic [DW-1:0] y_o,
    output logic          valid_o
);

    localparam int STAGES = 2;

    logic [STAGES:1] vld_pipe;

    // ---------------- Stage A ----------------
    logic              sign_a;
    logic [EXP_W-1:0]  exp_a;
    logic [MAN_W-1:0]  man_a;
    logic signed [7:0] k_s;
    logic signed [9:0] kc;
    logic [3:0]        lzc;
    logic signed [9:0] e_nxt;
    stage_a_t          a_nxt;
    stage_a_t          st_a;

    assign sign_a = p_i[FP16_W-1];
    assign exp_a  = p_i[FP16_W-2 -: EXP_W];
    assign man_a  = p_i[MAN_W-1:0];
    assign k_s    = k_i;

    always_comb begin
        if (int'(k_s) > K_MAX)      kc = 10'(K_MAX);
        else if (int'(k_s) < K_MIN) kc = 10'(K_MIN);
        else                        kc = 10'(k_s);
    end

    // Bit 10 of a subnormal significand is always 0, so lzc is 1..10 here.
    fp16_lzc11 u_lzc (
        .a   ({1'b0, man_a}),
        .cnt (lzc)
    );

    always_comb begin
        a_nxt      = '0;
        e_nxt      = '0;
        a_nxt.sign = sign_a;
        if (exp_a == EXP_W'(EXP_MAX)) begin
            a_nxt.cls = (man_a != '0) ? CLS_NAN : CLS_INF;
        end else if (exp_a == '0) begin
            if (man_a == '0) begin
                a_nxt.cls = CLS_ZERO;
            end else begin
                a_nxt.cls = CLS_SUB;
                a_nxt.sig = {1'b0, man_a} << lzc;
                e_nxt     = 10'sd1 - signed'({6'b0, lzc}) + kc;
            end
        end else begin
            a_nxt.cls = CLS_NORM;
            a_nxt.sig = {1'b1, man_a};
            e_nxt     = signed'({5'b0, exp_a}) + kc;
        end
        a_nxt.e_eff = e_nxt;
    end

    // ---------------- Stage B ----------------
    logic signed [9:0] e_b;
    logic signed [9:0] sh_s;
    logic [22:0]       ext_sft;
    logic [10:0]       shifted;
    logic              guard;
    logic              sticky;
    logic [10:0]       rnd;
    logic [DW-1:0]     y_nxt;

    assign e_b  = st_a.e_eff;
    assign sh_s = 10'sd1 - e_b;

    // Significand with 12 fraction bits appended: after the shift the top
    // 11 bits are the kept value, then guard, then the sticky field.
    // Only shifts up to 12 reach this path; larger ones flush to zero.
    assign ext_sft = {st_a.sig, 12'b0} >> sh_s[3:0];
    assign shifted = ext_sft[22:12];
    assign guard   = ext_sft[11];
    assign sticky  = |ext_sft[10:0];
    // Kept value is < 2^10, so a round-up can at most reach 0x400, which
    // lands on the exponent LSB and becomes the smallest normal.
    assign rnd     = shifted + 11'(guard & (sticky | shifted[0]));

    always_comb begin
        y_nxt = '0;
        case (st_a.cls)
            CLS_NAN:  y_nxt = QNAN;
            CLS_INF:  y_nxt = {st_a.sign, PINF[FP16_W-2:0]};
            CLS_ZERO: y_nxt = {st_a.sign, 15'b0};
            default: begin
                if (e_b >= 10'sd31)      y_nxt = {st_a.sign, PINF[FP16_W-2:0]};
                else if (e_b >= 10'sd1)  y_nxt = {st_a.sign, e_b[4:0], st_a.sig[MAN_W-1:0]};
                else if (sh_s > 10'sd12) y_nxt = {st_a.sign, 15'b0};
                else                     y_nxt = {st_a.sign, 4'b0, rnd};
            end
        endcase
    end

    // ---------------- Registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            st_a     <= '0;
            y_o      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], valid_i};
            if (valid_i)     st_a <= a_nxt;
            if (vld_pipe[1]) y_o  <= y_nxt;
        end
    end

    assign valid_o = vld_pipe[STAGES];

endmodule

// File: tb/tb_base2_k_combiner.sv
module tb_base2_k_combiner;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_i;
    logic [7:0]  k_i;
    logic [15:0] p_i;
    logic [15:0] y_o;
    logic        valid_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] y;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    localparam int NV = 16;
    // operand, k, hand-computed result
    logic [15:0] vp [NV] = '{16'h3C00, 16'h3E00, 16'h3E00, 16'h3C01,
                             16'h7BFF, 16'hBC00, 16'h7E01, 16'h8000,
                             16'h3C00, 16'h3C00, 16'h0001, 16'h3BFF,
                             16'hFC00, 16'hF800, 16'hBC00, 16'h7BFF};
    int          vk [NV] = '{3, -16, -24, -24,
                             1, 0, 5, 7,
                             100, -128, 10, -14,
                             -5, 2, -20, -128};
    logic [15:0] vy [NV] = '{16'h4800, 16'h0180, 16'h0002, 16'h0001,
                             16'h7C00, 16'hBC00, 16'h7E00, 16'h8000,
                             16'h7C00, 16'h0000, 16'h0400, 16'h0400,
                             16'hFC00, 16'hFC00, 16'h8010, 16'h0100};

    base2_k_combiner #(.DW(16), .K_MIN(-32), .K_MAX(32)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .valid_i (valid_i),
        .k_i     (k_i),
        .p_i     (p_i),
        .y_o     (y_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid_o must match the oldest expectation, exactly
    // two cycles after it was issued.
    always @(negedge clk) begin
        if (valid_o) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: y_o=%h valid_o=1 with nothing expected (cycle %0d)", y_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (y_o !== e.y || cyc != e.cyc + 2) begin
                    n_err++;
                    $display("FAIL result: y_o=%h at cycle %0d, want %h at cycle %0d", y_o, cyc, e.y, e.cyc + 2);
                end
            end
        end
    end

    task automatic issue(input int idx);
        exp_t e;
        valid_i = 1'b1;
        p_i     = vp[idx];
        k_i     = 8'(vk[idx]);
        e.y     = vy[idx];
        e.cyc   = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        n_cmp++;
        if (valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s_valid: valid_o=%b want 0", tag, valid_o);
        end
        n_cmp++;
        if (y_o !== 16'h0000) begin
            n_err++;
            $display("FAIL %s_y: y_o=%h want 0000", tag, y_o);
        end
    endtask

    initial begin
        rstn    = 1'b0;
        valid_i = 1'b0;
        k_i     = '0;
        p_i     = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Single transaction, then idle: exactly one output, and y_o holds.
        issue(0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (y_o !== 16'h4800) begin
            n_err++;
            $display("FAIL hold: y_o=%h want 4800", y_o);
        end
        @(posedge clk); #1;

        // Eight back-to-back mixed cases, then the rest back-to-back.
        for (int i = 1; i <= 8; i++) issue(i);
        repeat (4) @(posedge clk); #1;
        for (int i = 9; i < NV; i++) issue(i);
        repeat (4) @(posedge clk); #1;

        // Reset mid-stream: the two in-flight results are discarded.
        for (int i = 0; i < 4; i++) issue(i);
        rstn    = 1'b0;
        valid_i = 1'b0;
        sb.delete();
        #2;
        check_reset("midreset");
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 4; i < 8; i++) issue(i);

        // Drain with a bounded wait.
        for (int w = 0; w < 20 && sb.size() != 0; w++) begin
            @(negedge clk); #1;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, want 0", sb.size());
        end
        repeat (5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/base2_k_combiner.md
BASE2_K_COMBINER -- requirements
Module: base2_k_combiner

Interface
REQ-001 Parameter DW, default 16, data width; only the FP16 (1-5-10) encoding is supported.
REQ-002 Parameter K_MIN, default -32, lower clamp applied to k_i.
REQ-003 Parameter K_MAX, default 32, upper clamp applied to k_i.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rstn, input, 1, asynchronous active-low reset.
REQ-006 Port valid_i, input, 1, marks k_i/p_i valid this cycle; no backpressure.
REQ-007 Port k_i, input, 8, signed integer exponent, two's complement.
REQ-008 Port p_i, input, DW, FP16 operand (normally 2^f in [1,2)).
REQ-009 Port y_o, output, DW, FP16 result p_i * 2^k, registered.
REQ-010 Port valid_o, output, 1, marks y_o valid, registered.

Function
REQ-011 Block SHALL compute y = p * 2^kc, with kc = k_i clamped to [K_MIN, K_MAX].
REQ-012 Latency SHALL be exactly 2 cycles from valid_i to valid_o; throughput 1 result/cycle; back-to-back inputs SHALL produce back-to-back outputs.
REQ-013 Stage A SHALL register: sign, class (zero/subnormal/normal/inf/NaN), 11-bit normalized significand and signed 10-bit effective exponent e_eff = e + kc (subnormal p: e_eff = 1 - lzc + kc, significand left-shifted by lzc so bit10 = 1).
REQ-014 Stage B SHALL form the result and update y_o only when the Stage A valid is 1; y_o SHALL hold its last value otherwise.
REQ-015 NaN input SHALL give 0x7E00 (canonical quiet NaN), regardless of k.
REQ-016 ±Inf input SHALL give ±Inf (0x7C00/0xFC00).
REQ-017 ±0 input SHALL give ±0, sign preserved.
REQ-018 e_eff >= 31 SHALL give ±Inf (no saturation to max-finite).
REQ-019 1 <= e_eff <= 30 SHALL give {s, e_eff[4:0], significand[9:0]}, exact.
REQ-020 e_eff <= 0 SHALL right-shift the 11-bit significand by (1 - e_eff), round to nearest even using guard and sticky, exponent field 0.
REQ-021 Rounding carry out of a subnormal into bit10 SHALL give exponent 1 (e.g. 0x0400).
REQ-022 Shift amount > 12 SHALL give ±0.
REQ-023 valid_o SHALL follow the valid pipeline unconditionally; it is never gated by data class.

Reset
REQ-024 While rstn = 0: valid_o = 0, y_o = 0x0000, all stage registers and valid bits = 0.
REQ-025 Reset assertion mid-stream SHALL discard in-flight data; the first valid_o after release SHALL correspond to the first valid_i sampled after release.

Structure
REQ-026 FP16 constants (QNAN 0x7E00, PINF 0x7C00, bias 15, field widths) SHALL live in the shared fp16 package used by the activation blocks.
REQ-027 One sub-module, fp16_lzc11 (11-bit leading-zero count for subnormal normalization), SHALL be instantiated in Stage A; all other logic is inline.

Verification
REQ-028 p=0x3C00, k=3 -> y=0x4800 two cycles later, valid_o 1 for exactly one cycle.
REQ-029 p=0x3E00, k=-16 -> 0x0180; p=0x3E00, k=-24 -> 0x0002 (tie, rounds to even); p=0x3C01, k=-24 -> 0x0001.
REQ-030 p=0x7BFF, k=1 -> 0x7C00; p=0xBC00, k=0 -> 0xBC00; p=0x7E01, k=5 -> 0x7E00; p=0x8000, k=7 -> 0x8000.
REQ-031 k=100 with K_MAX=32 clamps: p=0x3C00 -> 0x7C00; k=-128 with K_MIN=-32, p=0x3C00 -> 0x0000.
REQ-032 Stream of 8 consecutive valid_i with mixed cases -> 8 consecutive valid_o in order; rstn pulsed low after 4 -> valid_o drops within reset, no stale outputs afterward.
